// File: rtl/bus_arb_mux.sv
// Multi-channel capture mux: fixed-select or round-robin arbitration into a registered valid/ready output.
// Optional sticky select-error flag (ERR/ERR_CLR) is compiled in with BUS_ARB_MUX_ERR_EN.
//
// state | meaning
// IDLE  | output register empty, DVALID=0, any eligible request loads immediately
// BUSY  | DBUS holds an unaccepted word, DVALID=1, reload only on DVALID&DREADY
module bus_arb_mux #(
   parameter int WIDTH = 16,
   parameter int NCH   = 4,
   parameter int SELW  = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NCH*WIDTH-1:0] D_IN,
   input  logic [NCH-1:0]       REQ,
   input  logic                 MODE,
   input  logic [SELW-1:0]      SEL,
   output logic [NCH-1:0]       GNT,
   output logic [WIDTH-1:0]     DBUS,
   output logic                 DVALID,
   input  logic                 DREADY
`ifdef BUS_ARB_MUX_ERR_EN
   ,
   output logic                 ERR,
   input  logic                 ERR_CLR
`endif
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]       state;
   logic [SELW-1:0]  last;
   logic             fix_hit;
   logic             rr_hit;
   int               rr_idx;
   int               rr_c;
   logic             pick_hit;
   int               pick_idx;
   logic             load_opp;
   logic             grant;
   logic [WIDTH-1:0] pick_data;

   // Fixed-select eligibility via compare loop so an out-of-range SEL never indexes REQ.
   always_comb begin
      fix_hit = 1'b0;
      for (int j = 0; j < NCH; j++) begin
         if (SEL == SELW'(j)) fix_hit = REQ[j];
      end
   end

   // Round-robin: first requester searching upward from last+1, wrapping.
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = 0;
      rr_c   = 0;
      for (int off = 1; off <= NCH; off++) begin
         rr_c = (int'(last) + off) % NCH;
         for (int j = 0; j < NCH; j++) begin
            if (!rr_hit && (j == rr_c) && REQ[j]) begin
               rr_hit = 1'b1;
               rr_idx = j;
            end
         end
      end
   end

   always_comb begin
      pick_hit  = MODE ? rr_hit : fix_hit;
      pick_idx  = MODE ? rr_idx : int'(SEL);
      load_opp  = (state == IDLE) || DREADY;
      grant     = load_opp && pick_hit && !RST;
      GNT       = '0;
      pick_data = '0;
      for (int j = 0; j < NCH; j++) begin
         if (j == pick_idx) begin
            GNT[j]    = grant;
            pick_data = D_IN[j*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         DBUS  <= '0;
         last  <= SELW'(NCH - 1);
      end else if (grant) begin
         state <= BUSY;
         DBUS  <= pick_data;
         last  <= SELW'(pick_idx);
      end else if ((state == BUSY) && DREADY) begin
         state <= IDLE;
      end
   end

   assign DVALID = (state == BUSY);

`ifdef BUS_ARB_MUX_ERR_EN
   logic err_set;

   // A fixed-mode load opportunity wasted on a non-requesting or nonexistent channel.
   assign err_set = load_opp && !MODE && (|REQ) && !fix_hit;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)          ERR <= 1'b0;
      else if (err_set) ERR <= 1'b1;
      else if (ERR_CLR) ERR <= 1'b0;
   end
`endif

endmodule
